alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter.sv | 162 ++++++++++++++++
 tb/tb_alu_arbiter.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : alu_arbiter                                                     |
// | Purpose  : Round-robin arbiter sharing one combinational ALU among N_REQ   |
// |            requesters through a two-stage pipeline (issue, then result).   |
// | Option   : ALU_ARB_ERR_EN adds sticky illegal-opcode flags.                |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module alu_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int N_REQ      = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [N_REQ-1:0]            req_valid,
  output logic [N_REQ-1:0]            req_ready,
  input  logic [3*N_REQ-1:0]          req_ctrl,
  input  logic [DATA_WIDTH*N_REQ-1:0] req_in0,
  input  logic [DATA_WIDTH*N_REQ-1:0] req_in1,
  output logic [2:0]                  alu_ctrl,
  output logic [DATA_WIDTH-1:0]       alu_in0,
  output logic [DATA_WIDTH-1:0]       alu_in1,
  input  logic [DATA_WIDTH-1:0]       alu_out,
  output logic [N_REQ-1:0]            rsp_valid,
  output logic [DATA_WIDTH-1:0]       rsp_data
`ifdef ALU_ARB_ERR_EN
  ,
  output logic                        err_illegal,
  output logic [N_REQ-1:0]            err_src
`endif
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [N_REQ-1:0] ONE_HOT0 = {{(N_REQ-1){1'b0}}, 1'b1};

  logic [2:0]            ctrl_arr [N_REQ];
  logic [DATA_WIDTH-1:0] in0_arr  [N_REQ];
  logic [DATA_WIDTH-1:0] in1_arr  [N_REQ];

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
    assign ctrl_arr[gi] = req_ctrl[3*gi +: 3];
    assign in0_arr[gi]  = req_in0[DATA_WIDTH*gi +: DATA_WIDTH];
    assign in1_arr[gi]  = req_in1[DATA_WIDTH*gi +: DATA_WIDTH];
  end

  logic [IDX_W-1:0]      last_grant_q, last_grant_d;
  logic                  s1_valid_q, s1_valid_d;
  logic [IDX_W-1:0]      s1_owner_q, s1_owner_d;
  logic [2:0]            alu_ctrl_q, alu_ctrl_d;
  logic [DATA_WIDTH-1:0] alu_in0_q, alu_in0_d;
  logic [DATA_WIDTH-1:0] alu_in1_q, alu_in1_d;
  logic [N_REQ-1:0]      rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;

  logic [IDX_W-1:0]      grant_idx;
  logic [IDX_W-1:0]      cand_idx;
  logic                  grant_found;
  logic                  accept;
  int                    cand;

  // Walk the ring starting just after the previous winner; first valid wins.
  always_comb begin
    grant_idx   = last_grant_q;
    grant_found = 1'b0;
    cand        = 0;
    cand_idx    = '0;
    for (int off = 1; off <= N_REQ; off++) begin
      cand     = (int'(last_grant_q) + off) % N_REQ;
      cand_idx = IDX_W'(cand);
      if (!grant_found && req_valid[cand_idx]) begin
        grant_found = 1'b1;
        grant_idx   = cand_idx;
      end
    end
  end

  assign accept    = grant_found && !reset;
  assign req_ready = accept ? (ONE_HOT0 << grant_idx) : '0;

  always_comb begin
    last_grant_d = last_grant_q;
    s1_valid_d   = accept;
    s1_owner_d   = s1_owner_q;
    alu_ctrl_d   = alu_ctrl_q;
    alu_in0_d    = alu_in0_q;
    alu_in1_d    = alu_in1_q;
    if (accept) begin
      last_grant_d = grant_idx;
      s1_owner_d   = grant_idx;
      alu_ctrl_d   = ctrl_arr[grant_idx];
      alu_in0_d    = in0_arr[grant_idx];
      alu_in1_d    = in1_arr[grant_idx];
    end
  end

  // Compare ops return only the flag bit; opcodes 6/7 complete with zero.
  always_comb begin
    rsp_valid_d = '0;
    rsp_data_d  = rsp_data_q;
    if (s1_valid_q) begin
      rsp_valid_d = ONE_HOT0 << s1_owner_q;
      case (alu_ctrl_q)
        3'd3, 3'd4, 3'd5: rsp_data_d = {{(DATA_WIDTH-1){1'b0}}, alu_out[0]};
        3'd6, 3'd7:       rsp_data_d = '0;
        default:          rsp_data_d = alu_out;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant_q <= IDX_W'(N_REQ - 1);
      s1_valid_q   <= 1'b0;
      s1_owner_q   <= '0;
      alu_ctrl_q   <= '0;
      alu_in0_q    <= '0;
      alu_in1_q    <= '0;
      rsp_valid_q  <= '0;
      rsp_data_q   <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      s1_valid_q   <= s1_valid_d;
      s1_owner_q   <= s1_owner_d;
      alu_ctrl_q   <= alu_ctrl_d;
      alu_in0_q    <= alu_in0_d;
      alu_in1_q    <= alu_in1_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_data_q   <= rsp_data_d;
    end
  end

  assign alu_ctrl  = alu_ctrl_q;
  assign alu_in0   = alu_in0_q;
  assign alu_in1   = alu_in1_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;

`ifdef ALU_ARB_ERR_EN
  logic             err_illegal_q;
  logic [N_REQ-1:0] err_src_q;
  logic             illegal_accept;

  assign illegal_accept = accept && (ctrl_arr[grant_idx][2:1] == 2'b11);

  always_ff @(posedge clk) begin
    if (reset) begin
      err_illegal_q <= 1'b0;
      err_src_q     <= '0;
    end else if (illegal_accept) begin
      err_illegal_q <= 1'b1;
      err_src_q     <= err_src_q | req_ready;
    end
  end

  assign err_illegal = err_illegal_q;
  assign err_src     = err_src_q;
`else
  // Illegal opcodes still complete with zero data; no flags are kept.
`endif

endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_alu_arbiter                                                  |
// | Purpose  : Directed self-checking bench for alu_arbiter with a simple ALU. |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_alu_arbiter;

  localparam int DW = 32;
  localparam int N  = 4;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [3*N-1:0]  req_ctrl;
  logic [DW*N-1:0] req_in0;
  logic [DW*N-1:0] req_in1;
  logic [2:0]      alu_ctrl;
  logic [DW-1:0]   alu_in0;
  logic [DW-1:0]   alu_in1;
  logic [DW-1:0]   alu_out;
  logic [N-1:0]    rsp_valid;
  logic [DW-1:0]   rsp_data;
`ifdef ALU_ARB_ERR_EN
  logic            err_illegal;
  logic [N-1:0]    err_src;
`endif

  int n_checks = 0;
  int n_errors = 0;

  alu_arbiter #(.DATA_WIDTH(DW), .N_REQ(N)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_ctrl  (req_ctrl),
    .req_in0   (req_in0),
    .req_in1   (req_in1),
    .alu_ctrl  (alu_ctrl),
    .alu_in0   (alu_in0),
    .alu_in1   (alu_in1),
    .alu_out   (alu_out),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data)
`ifdef ALU_ARB_ERR_EN
    ,
    .err_illegal (err_illegal),
    .err_src     (err_src)
`endif
  );

  always #5 clk = ~clk;

  // Compare results carry junk in the upper bits so zero-extension is visible.
  always_comb begin
    case (alu_ctrl)
      3'd0, 3'd1: alu_out = alu_in0 + alu_in1;
      3'd2:       alu_out = alu_in0 - alu_in1;
      3'd3:       alu_out = {~31'd0, alu_in0 == alu_in1};
      3'd4:       alu_out = {~31'd0, alu_in0 < alu_in1};
      3'd5:       alu_out = {~31'd0, alu_in0 > alu_in1};
      default:    alu_out = 32'hDEAD_BEEF;
    endcase
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_req(input int i, input logic v, input logic [2:0] c,
                         input logic [DW-1:0] a, input logic [DW-1:0] b);
    req_valid[i]          = v;
    req_ctrl[3*i +: 3]    = c;
    req_in0[DW*i +: DW]   = a;
    req_in1[DW*i +: DW]   = b;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset     = 1'b1;
    req_valid = '0;
    req_ctrl  = '0;
    req_in0   = '0;
    req_in1   = '0;

    // Reset state; a pending request must not be granted while in reset
    set_req(0, 1'b1, 3'd1, 32'd5, 32'd7);
    #2;
    check("rdy_in_reset", req_ready, 4'b0000);
    step();
    step();
    check("rst_rsp_valid", rsp_valid, 4'b0000);
    check("rst_rsp_data", rsp_data, 32'd0);
    check("rst_alu_ctrl", alu_ctrl, 3'd0);
    check("rst_alu_in0", alu_in0, 32'd0);
    check("rst_alu_in1", alu_in1, 32'd0);

    // Single add from requester 0
    reset = 1'b0;
    #1;
    check("single_rdy", req_ready, 4'b0001);
    step();
    req_valid = '0;
    check("single_alu_ctrl", alu_ctrl, 3'd1);
    check("single_alu_in0", alu_in0, 32'd5);
    check("single_no_rsp_yet", rsp_valid, 4'b0000);
    step();
    check("single_rsp_valid", rsp_valid, 4'b0001);
    check("single_rsp_data", rsp_data, 32'd12);
    step();
    check("single_rsp_clear", rsp_valid, 4'b0000);
    check("single_data_hold", rsp_data, 32'd12);

    // All four requesters continuously valid from reset
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int i = 0; i < N; i++) set_req(i, 1'b1, 3'd0, DW'(i), 32'd0);
    for (int t = 0; t < 5; t++) begin
      #1;
      check("rr_rdy", req_ready, 4'(1) << (t % 4));
      step();
      if (t > 0) begin
        check("rr_rsp_valid", rsp_valid, 4'(1) << ((t - 1) % 4));
        check("rr_rsp_data", rsp_data, 32'((t - 1) % 4));
      end
    end
    req_valid = '0;
    step();
    check("rr_last_valid", rsp_valid, 4'b0001);
    check("rr_last_data", rsp_data, 32'd0);

    // Compare result is zero-extended after an all-ones result
    set_req(0, 1'b1, 3'd0, 32'hFFFF_FFFF, 32'd0);
    #1;
    check("cmp_pre_rdy", req_ready, 4'b0001);
    step();
    set_req(0, 1'b1, 3'd4, 32'd3, 32'd9);
    #1;
    check("cmp_rdy", req_ready, 4'b0001);
    step();
    check("cmp_pre_data", rsp_data, 32'hFFFF_FFFF);
    req_valid = '0;
    step();
    check("cmp_valid", rsp_valid, 4'b0001);
    check("cmp_data", rsp_data, 32'd1);

    // Illegal opcode from requester 2
    set_req(2, 1'b1, 3'd7, 32'd11, 32'd22);
    #1;
    check("ill_rdy", req_ready, 4'b0100);
    step();
    req_valid = '0;
    step();
    check("ill_valid", rsp_valid, 4'b0100);
    check("ill_data", rsp_data, 32'd0);
`ifdef ALU_ARB_ERR_EN
    check("ill_err", err_illegal, 1'b1);
    check("ill_src", err_src, 4'b0100);
`endif
    step();
    check("ill_valid_clear", rsp_valid, 4'b0000);
`ifdef ALU_ARB_ERR_EN
    check("ill_err_sticky", err_illegal, 1'b1);
    check("ill_src_sticky", err_src, 4'b0100);
`endif

    // Fairness: requester 1 always valid, requester 3 pulses
    set_req(1, 1'b1, 3'd2, 32'd10, 32'd3);
    #1;
    check("fair_a_rdy", req_ready, 4'b0010);
    step();
    set_req(3, 1'b1, 3'd2, 32'd20, 32'd5);
    #1;
    check("fair_b_rdy", req_ready, 4'b1000);
    step();
    check("fair_b_rsp", rsp_valid, 4'b0010);
    check("fair_b_data", rsp_data, 32'd7);
    req_valid[3] = 1'b0;
    #1;
    check("fair_c_rdy", req_ready, 4'b0010);
    step();
    check("fair_c_rsp", rsp_valid, 4'b1000);
    check("fair_c_data", rsp_data, 32'd15);
    req_valid[3] = 1'b1;
    #1;
    check("fair_d_rdy", req_ready, 4'b1000);
    step();
    check("fair_d_rsp", rsp_valid, 4'b0010);
    req_valid = '0;
    step();
    check("fair_e_rsp", rsp_valid, 4'b1000);
    check("fair_e_data", rsp_data, 32'd15);

    // Idle cycles and a withdrawn request leave the pointer at 3
    step();
    step();
    req_valid = 4'b1111;
    #1;
    check("idle_keep_rdy", req_ready, 4'b0001);
    req_valid = '0;
    #1;
    check("none_valid_rdy", req_ready, 4'b0000);
    step();
    req_valid = 4'b0110;
    #1;
    check("withdraw_rdy", req_ready, 4'b0010);
    req_valid = '0;
    step();
    check("withdraw_no_rsp", rsp_valid, 4'b0000);

    // Reset one edge after an accept drops the operation
    set_req(1, 1'b1, 3'd1, 32'd1, 32'd1);
    #1;
    check("midrst_rdy", req_ready, 4'b0010);
    step();
    reset     = 1'b1;
    req_valid = 4'b0100;
    #1;
    check("midrst_rdy_in_reset", req_ready, 4'b0000);
    step();
    check("midrst_drop1", rsp_valid, 4'b0000);
    step();
    check("midrst_drop2", rsp_valid, 4'b0000);
    check("midrst_data", rsp_data, 32'd0);
    check("midrst_alu_in0", alu_in0, 32'd0);
`ifdef ALU_ARB_ERR_EN
    check("midrst_err_clear", err_illegal, 1'b0);
    check("midrst_src_clear", err_src, 4'b0000);
`endif
    reset     = 1'b0;
    req_valid = 4'b1111;
    #1;
    check("midrst_first", req_ready, 4'b0001);
    step();
    req_valid = '0;
    check("midrst_no_stale", rsp_valid, 4'b0000);
    step();
    check("midrst_rsp", rsp_valid, 4'b0001);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
